branch_resolve: RTL
===================

Name: branch_resolve

Overview:
- Execute-stage branch resolution unit, directly downstream of the fetch-side perceptron/bimodal predictor.
- Consumes each control-transfer instruction plus the prediction metadata carried down the pipeline, and computes the actual direction and target.
- Detects mispredictions, drives the predictor's execute_bpredictor_* update/RAS-repair interface, and issues a front-end redirect/flush.
- Holds a pending update across soin_bpredictor_stall so that no training event is lost.

Parameters:
- FLUSH_CYCLES, 2, cycles of wrong-path squash after a redirect (1..7).
- PC_W, 32, PC/target width.
- META_W, 12, width of the predictor metadata (bimodal/perceptron carry).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  instruction in execute is valid
- ex_inst  in  32  Nios II instruction word
- ex_PC4  in  PC_W  PC+4 of the instruction
- ex_rA  in  32  operand A
- ex_rB  in  32  operand B
- ex_p_dir  in  1  predicted direction
- ex_p_target  in  PC_W  predicted next PC
- ex_meta  in  META_W  predictor metadata
- soin_bpredictor_stall  in  1  global stall
- execute_bpredictor_update  out  1  train predictor this cycle
- execute_bpredictor_PC4  out  PC_W  PC+4 of resolved branch
- execute_bpredictor_target  out  PC_W  actual target
- execute_bpredictor_dir  out  1  actual direction
- execute_bpredictor_miss  out  1  misprediction
- execute_bpredictor_bimodal  out  META_W  metadata echoed back
- execute_missPred  out  1  redirect pulse
- execute_isCall  out  1  resolved branch is call/callr
- execute_c_r_after_r  out  1  call/return resolved directly after a return
- redirect_PC  out  PC_W  correct next PC
- flush  out  1  squash wrong-path instructions

Behaviour:
- Decode:
  - opcode = inst[5:0]; opx = inst[16:11].
  - Conditional branches: beq 0x26, bne 0x1e, bge 0x0e, bgeu 0x2e, blt 0x16, bltu 0x36. Unconditional: br 0x06.
  - Direct jumps: call 0x00, jmpi 0x01.
  - Opcode 0x3a with opx 0x1d callr, 0x0d jmp, 0x05 ret, 0x01 eret.
  - Any other instruction is ignored: no update.
- Direction: conditional branches compare rA vs rB, signed or unsigned as the opcode requires. All other recognised branches are taken (dir = 1).
- Target arithmetic:
  - Branch opcodes: PC4 + sign_extend(inst[21:6]), modulo 2^PC_W.
  - call/jmpi: {PC4[31:28], inst[31:6], 2'b00}.
  - Opcode 0x3a: rA.
- Miss rule: miss = (dir != p_dir) | (dir & (p_target != target)). Not-taken branches compare direction only.
- Acceptance: a branch is accepted when ex_valid & ~soin_bpredictor_stall & state == IDLE.
- Registered outputs, 1-cycle latency: all execute_bpredictor_* fields, update = 1, missPred = miss, redirect_PC = dir ? target : PC4.
- Default outputs: update and missPred are single-cycle pulses. Data fields hold their last value.
- Stall hold: if soin_bpredictor_stall is high while update = 1, update and all fields stay held until the first cycle stall is low, then deassert. missPred pulses only once, on acceptance.
- FSM:
  - IDLE -> FLUSH on an accepted miss. Counter is loaded with FLUSH_CYCLES.
  - FLUSH: flush = 1; counter decrements only when not stalled; ex_valid is ignored.
  - FLUSH -> IDLE when the counter reaches 1 and is not stalled.
  - FLUSH_CYCLES = 1 gives exactly one flush cycle.
- RAS repair:
  - last_ret register is set by an accepted ret and cleared by any other accepted branch.
  - execute_c_r_after_r = last_ret & (call|callr|ret); it is registered together with the update.
  - execute_isCall is registered with the update.
- Reset (active low, asynchronous):
  - All outputs 0, including redirect_PC and fields.
  - State IDLE, last_ret 0.
  - Reset mid-FLUSH aborts immediately.
- Simultaneous stall and ex_valid: the instruction is not accepted; upstream re-presents it.

Optional Feature:
- BRANCH_RESOLVE_PERF_EN.
- Defined: adds 32-bit saturating counters br_count, miss_count, flush_cycles. They are readable on output perf_data[31:0] selected by input perf_sel[1:0] (3 = 0). Counters clear on reset.
- Undefined: the ports and counters are absent, and there is no other change.

Decomposition:
- Shared package: opcode/opx localparams, branch_kind enum (COND, BR, DIRECT, INDIRECT, RET, CALLR), FSM state typedef.
- One natural sub-module, branch_resolve_cmp: purely combinational condition/target evaluator.
- The top level keeps the FSM, hold register and RAS tracking.

Test Plan:
- beq with rA = rB = 5, p_dir = 0, PC4 = 0x104, imm = 8 -> next cycle update = 1, dir = 1, target = 0x10C, miss = 1, redirect_PC = 0x10C; flush high for 2 cycles.
- bltu with rA = 0xFFFFFFFF, rB = 1, p_dir = 0 -> dir = 0, miss = 0, no flush, redirect_PC = PC4.
- Correctly predicted call: inst[31:6] = 0x40, PC4 = 0x20000004, p_target = 0x20000100 -> target 0x20000100, miss = 0, isCall = 1.
- ret then callr back-to-back -> the second update has c_r_after_r = 1; the first has c_r_after_r = 0.
- Miss accepted, then soin_bpredictor_stall high 3 cycles -> update held 3 cycles, missPred single pulse, flush lasts 2 unstalled cycles.
- reset asserted while in FLUSH -> flush = 0 and update = 0 asynchronously; a following ex_valid branch is accepted normally after release.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared decode constants, branch classification and FSM state type for branch_resolve.
// Optional macro BRANCH_RESOLVE_PERF_EN is consumed by the top level only.
package branch_resolve_pkg;

  localparam logic [5:0] OP_BEQ   = 6'h26;
  localparam logic [5:0] OP_BNE   = 6'h1e;
  localparam logic [5:0] OP_BGE   = 6'h0e;
  localparam logic [5:0] OP_BGEU  = 6'h2e;
  localparam logic [5:0] OP_BLT   = 6'h16;
  localparam logic [5:0] OP_BLTU  = 6'h36;
  localparam logic [5:0] OP_BR    = 6'h06;
  localparam logic [5:0] OP_CALL  = 6'h00;
  localparam logic [5:0] OP_JMPI  = 6'h01;
  localparam logic [5:0] OP_RTYPE = 6'h3a;

  localparam logic [5:0] OPX_CALLR = 6'h1d;
  localparam logic [5:0] OPX_JMP   = 6'h0d;
  localparam logic [5:0] OPX_RET   = 6'h05;
  localparam logic [5:0] OPX_ERET  = 6'h01;

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    NONE,
    COND,
    BR,
    DIRECT,
    INDIRECT,
    RET,
    CALLR
  } branch_kind_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1
  } state_t;

  // NONE marks any instruction that is not a control transfer and must not train.
  function automatic branch_kind_t decode_kind(input logic [31:0] inst);
    branch_kind_t k;
    k = NONE;
    case (inst[5:0])
      OP_BEQ, OP_BNE, OP_BGE, OP_BGEU, OP_BLT, OP_BLTU: k = COND;
      OP_BR:            k = BR;
      OP_CALL, OP_JMPI: k = DIRECT;
      OP_RTYPE: begin
        case (inst[16:11])
          OPX_CALLR:         k = CALLR;
          OPX_JMP, OPX_ERET: k = INDIRECT;
          OPX_RET:           k = RET;
          default:           k = NONE;
        endcase
      end
      default: k = NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Execute-stage bundle: instruction + prediction metadata in, predictor update and redirect out.
// master = pipeline/predictor side, slave = branch_resolve.
interface branch_resolve_if #(
  parameter int PC_W   = 32,
  parameter int META_W = 12
);
  // ex_valid offers an instruction; it is taken only in a cycle with soin_bpredictor_stall low
  // while the unit is idle, otherwise upstream keeps presenting it.
  logic              ex_valid;
  logic [31:0]       ex_inst;
  logic [PC_W-1:0]   ex_PC4;
  logic [31:0]       ex_rA;
  logic [31:0]       ex_rB;
  logic              ex_p_dir;
  logic [PC_W-1:0]   ex_p_target;
  logic [META_W-1:0] ex_meta;
  logic              soin_bpredictor_stall;

  logic              execute_bpredictor_update;
  logic [PC_W-1:0]   execute_bpredictor_PC4;
  logic [PC_W-1:0]   execute_bpredictor_target;
  logic              execute_bpredictor_dir;
  logic              execute_bpredictor_miss;
  logic [META_W-1:0] execute_bpredictor_bimodal;
  logic              execute_missPred;
  logic              execute_isCall;
  logic              execute_c_r_after_r;
  logic [PC_W-1:0]   redirect_PC;
  logic              flush;

  modport master (
    output ex_valid, ex_inst, ex_PC4, ex_rA, ex_rB, ex_p_dir, ex_p_target, ex_meta,
           soin_bpredictor_stall,
    input  execute_bpredictor_update, execute_bpredictor_PC4, execute_bpredictor_target,
           execute_bpredictor_dir, execute_bpredictor_miss, execute_bpredictor_bimodal,
           execute_missPred, execute_isCall, execute_c_r_after_r, redirect_PC, flush
  );

  modport slave (
    input  ex_valid, ex_inst, ex_PC4, ex_rA, ex_rB, ex_p_dir, ex_p_target, ex_meta,
           soin_bpredictor_stall,
    output execute_bpredictor_update, execute_bpredictor_PC4, execute_bpredictor_target,
           execute_bpredictor_dir, execute_bpredictor_miss, execute_bpredictor_bimodal,
           execute_missPred, execute_isCall, execute_c_r_after_r, redirect_PC, flush
  );
endinterface

// File: rtl/branch_resolve_cmp.sv
// Combinational branch evaluator: actual direction and target for one decoded instruction.
// Direct-jump targets keep the upper PC4 nibble, so PC_W must be in 28..32.
module branch_resolve_cmp
  import branch_resolve_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  branch_kind_t    i_kind,
  input  logic [31:0]     i_inst,
  input  logic [PC_W-1:0] i_pc4,
  input  logic [31:0]     i_ra,
  input  logic [31:0]     i_rb,
  output logic            o_dir,
  output logic [PC_W-1:0] o_target
);

  logic [5:0]      w_opcode;
  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;
  logic [PC_W-1:0] w_imm;
  logic [PC_W-1:0] w_rel;
  logic [PC_W-1:0] w_abs;

  assign w_opcode = i_inst[5:0];
  assign w_eq     = (i_ra == i_rb);
  assign w_lt_s   = ($signed(i_ra) < $signed(i_rb));
  assign w_lt_u   = (i_ra < i_rb);
  assign w_imm    = {{(PC_W-16){i_inst[21]}}, i_inst[21:6]};
  assign w_rel    = i_pc4 + w_imm;

  always_comb begin
    w_abs       = i_pc4;
    w_abs[27:0] = {i_inst[31:6], 2'b00};
  end

  always_comb begin
    o_dir    = 1'b1;
    o_target = i_ra[PC_W-1:0];
    case (i_kind)
      COND: begin
        o_target = w_rel;
        case (w_opcode)
          OP_BEQ:  o_dir = w_eq;
          OP_BNE:  o_dir = ~w_eq;
          OP_BGE:  o_dir = ~w_lt_s;
          OP_BGEU: o_dir = ~w_lt_u;
          OP_BLT:  o_dir = w_lt_s;
          OP_BLTU: o_dir = w_lt_u;
          default: o_dir = 1'b0;
        endcase
      end
      BR:                    o_target = w_rel;
      DIRECT:                o_target = w_abs;
      INDIRECT, RET, CALLR:  o_target = i_ra[PC_W-1:0];
      default:               o_dir    = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: predictor training, misprediction redirect and wrong-path flush.
// Optional BRANCH_RESOLVE_PERF_EN adds saturating perf counters read through perf_sel/perf_data.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 32,
  parameter int META_W       = 12
) (
  input  logic            clk,
  input  logic            reset,
  branch_resolve_if.slave bus,
`ifdef BRANCH_RESOLVE_PERF_EN
  input  logic [1:0]      perf_sel,
  output logic [31:0]     perf_data,
`endif
  output state_t          o_dbg_state
);

  localparam logic [CNT_W-1:0] LP_FLUSH = CNT_W'(FLUSH_CYCLES);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  branch_kind_t      w_kind;
  logic              w_dir;
  logic [PC_W-1:0]   w_target;
  logic              w_miss;
  logic              w_accept;
  logic              w_is_call;
  logic              w_is_ret;
  logic              w_stall;

  logic              r_update;
  logic [PC_W-1:0]   r_pc4;
  logic [PC_W-1:0]   r_target;
  logic              r_dir;
  logic              r_miss;
  logic [META_W-1:0] r_meta;
  logic              r_missPred;
  logic              r_isCall;
  logic              r_c_r_after_r;
  logic [PC_W-1:0]   r_redirect;
  logic              r_last_ret;

  assign w_kind    = decode_kind(bus.ex_inst);
  assign w_stall   = bus.soin_bpredictor_stall;
  assign w_is_ret  = (w_kind == RET);
  assign w_is_call = (w_kind == CALLR) | ((w_kind == DIRECT) & (bus.ex_inst[5:0] == OP_CALL));

  branch_resolve_cmp #(.PC_W(PC_W)) u_cmp (
    .i_kind   (w_kind),
    .i_inst   (bus.ex_inst),
    .i_pc4    (bus.ex_PC4),
    .i_ra     (bus.ex_rA),
    .i_rb     (bus.ex_rB),
    .o_dir    (w_dir),
    .o_target (w_target)
  );

  // A not-taken branch never compares targets: the predicted target is meaningless then.
  assign w_miss = (w_dir != bus.ex_p_dir) | (w_dir & (bus.ex_p_target != w_target));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = bus.ex_valid & ~w_stall & (w_kind != NONE);
        if (w_accept & w_miss) begin
          w_next_state = FLUSH;
          w_next_cnt   = LP_FLUSH;
        end
      end
      FLUSH: begin
        if (!w_stall) begin
          if (r_cnt <= CNT_W'(1)) w_next_state = IDLE;
          w_next_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Update is held while stalled so the predictor sees it in the first unstalled cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_update      <= 1'b0;
      r_pc4         <= '0;
      r_target      <= '0;
      r_dir         <= 1'b0;
      r_miss        <= 1'b0;
      r_meta        <= '0;
      r_missPred    <= 1'b0;
      r_isCall      <= 1'b0;
      r_c_r_after_r <= 1'b0;
      r_redirect    <= '0;
      r_last_ret    <= 1'b0;
    end else begin
      r_missPred <= w_accept & w_miss;
      if (w_accept) begin
        r_update      <= 1'b1;
        r_pc4         <= bus.ex_PC4;
        r_target      <= w_target;
        r_dir         <= w_dir;
        r_miss        <= w_miss;
        r_meta        <= bus.ex_meta;
        r_isCall      <= w_is_call;
        r_c_r_after_r <= r_last_ret & (w_is_call | w_is_ret);
        r_redirect    <= w_dir ? w_target : bus.ex_PC4;
        r_last_ret    <= w_is_ret;
      end else begin
        r_update <= r_update & w_stall;
      end
    end
  end

  assign bus.execute_bpredictor_update  = r_update;
  assign bus.execute_bpredictor_PC4     = r_pc4;
  assign bus.execute_bpredictor_target  = r_target;
  assign bus.execute_bpredictor_dir     = r_dir;
  assign bus.execute_bpredictor_miss    = r_miss;
  assign bus.execute_bpredictor_bimodal = r_meta;
  assign bus.execute_missPred           = r_missPred;
  assign bus.execute_isCall             = r_isCall;
  assign bus.execute_c_r_after_r        = r_c_r_after_r;
  assign bus.redirect_PC                = r_redirect;
  assign bus.flush                      = (r_state == FLUSH);
  assign o_dbg_state                    = r_state;

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [31:0] r_br_count;
  logic [31:0] r_miss_count;
  logic [31:0] r_flush_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_br_count     <= '0;
      r_miss_count   <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (w_accept && (r_br_count != '1))            r_br_count     <= r_br_count + 32'd1;
      if (w_accept && w_miss && (r_miss_count != '1)) r_miss_count   <= r_miss_count + 32'd1;
      if ((r_state == FLUSH) && (r_flush_cycles != '1)) r_flush_cycles <= r_flush_cycles + 32'd1;
    end
  end

  always_comb begin
    perf_data = '0;
    case (perf_sel)
      2'd0:    perf_data = r_br_count;
      2'd1:    perf_data = r_miss_count;
      2'd2:    perf_data = r_flush_cycles;
      default: perf_data = '0;
    endcase
  end
`endif

endmodule
